// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 (even parity bit)
module uart_tx_fifo #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_byte,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(CPB);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t         state_q, state_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]    count_q, count_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d;
  logic           tx_q, tx_d, busy_q, busy_d, push, pop, last;
  assign tx_ready   = count_q != (AW+1)'(FIFO_DEPTH);
  assign push       = tx_valid & tx_ready;
  assign last       = baud_q == BW'(CPB - 1);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d  = '0;
        pop     = count_q != '0;
        state_d = pop ? START : IDLE;
        tx_d    = !pop;
      end
      START: if (last) begin
        state_d = DATA;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = sh_q[0];
      end
      DATA: if (last) begin
        baud_d = '0;
        bit_d  = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = ^sh_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else
          tx_d = sh_q[bit_q + 3'd1];
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (last) begin
        state_d = STOP;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (last) begin
        // Chain straight into the next frame when bytes are waiting
        baud_d  = '0;
        pop     = count_q != '0;
        state_d = pop ? START : IDLE;
        tx_d    = !pop;
      end
      default: state_d = IDLE;
    endcase
    sh_d    = pop ? mem_q[rd_q] : sh_q;
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    busy_d  = (state_d != IDLE) | (count_d != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= tx_byte;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: random and directed pushes checked cycle by cycle against a frame-schedule model
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * CPB;
  logic       clk = 1'b0, rst = 1'b1, tx_valid = 1'b0, tx_ready, tx, busy;
  logic [7:0] tx_byte = '0;
  logic [2:0] fifo_count;
  int cyc = 0, n_chk = 0, n_fail = 0, n = 0;
  int pt [1024], st [1024];
  logic [7:0] bt [1024];
  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(250_000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx(tx), .busy(busy), .fifo_count(fifo_count));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
    end
  endtask
  // A byte accepted at edge P starts its frame at the later of P+1 and the end of the previous frame
  task automatic record(input int p, input logic [7:0] b);
    pt[n] = p;
    bt[n] = b;
    st[n] = (n == 0 || p + 1 > st[n-1] + F) ? p + 1 : st[n-1] + F;
    n++;
  endtask
  always @(negedge clk) if (cyc > 0) begin
    int cnt, k, etx, ebusy;
    logic [7:0] b;
    cnt = 0; etx = 1; ebusy = 0;
    for (int i = 0; i < n; i++) begin
      cnt += (pt[i] <= cyc) - (st[i] <= cyc);
      if (st[i] <= cyc && cyc < st[i] + F) begin
        ebusy = 1;
        k = (cyc - st[i]) / CPB;
        b = bt[i];
        etx = (k == 0) ? 0 : (k <= 8) ? int'(b[k-1]) : (NB == 11 && k == 9) ? int'(^b) : 1;
      end
    end
    chk("tx", tx, etx);
    chk("fifo_count", fifo_count, cnt);
    chk("busy", busy, (cnt > 0) || ebusy);
    chk("tx_ready", tx_ready, cnt != DEPTH);
  end
  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk); #1;
      tx_valid = 1'b0;
      tx_byte  = 8'($urandom);
    end
  endtask
  task automatic idle_to(input int t);
    while (cyc < t) idle(1);
  endtask
  task automatic push(input logic [7:0] b);
    bit done = 0;
    for (int w = 0; w < 2000 && !done; w++) begin
      @(negedge clk); #1;
      tx_valid = 1'b1;
      tx_byte  = b;
      #1;
      if (tx_ready) begin
        record(cyc + 1, b);
        done = 1;
      end
    end
    if (!done) chk("push_timeout", 0, 1);
  endtask
  task automatic drain();
    if (n > 0) idle_to(st[n-1] + F + 8);
    else idle(8);
  endtask
  initial begin
    int sb;
    idle(3);
    @(negedge clk); #1 rst = 1'b0;
    idle(50);
    push(8'h55); drain();
    for (int i = 1; i <= 5; i++) push(8'(i));
    drain();
    push(8'h11); push(8'h22); push(8'h33);
    sb = st[n-2];
    idle_to(sb - 2);
    push(8'h44);
    idle(2);
    chk("simul_count", fifo_count, 2);
    drain();
    push(8'hA5); push(8'h5A); push(8'hC3);
    idle_to(st[n-3] + 4 * CPB + 1);
    @(negedge clk); #1;
    rst = 1'b1; tx_valid = 1'b0; n = 0;
    @(negedge clk); #1 rst = 1'b0;
    idle(60);
    push(8'h07); push(8'h03); drain();
    for (int i = 0; i < 250; i++) begin
      push(8'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 60));
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
